legv8_control_unit: RTL and testbench

LEGV8_CONTROL_UNIT -- requirements
Module: legv8_control_unit

---
 rtl/legv8_ctrl_pkg.sv | 96 +++++++++
 rtl/legv8_control_unit_if.sv | 27 ++
 rtl/legv8_decode.sv | 87 ++++++++
 rtl/legv8_control_unit.sv | 119 +++++++++++
 tb/tb_legv8_control_unit.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/legv8_ctrl_pkg.sv
// legv8_ctrl_pkg: shared definitions for the LEGv8 control unit.
//   - FSM state enum and instruction class enum
//   - ALU function-select codes, FS = {func[2:0], Binvert, Ainvert}
//   - opcode constants for every decoded instruction
//   - control-word field offsets, the NOP word and a packing helper
// Optional feature macro used by the decoder: LEGV8_SHIFT_EN (LSL/LSR decode).
package legv8_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_EXEC   = 2'd1,
        S_MEM    = 2'd2,
        S_BRANCH = 2'd3
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I       = 4'd2,
        CLS_LDUR    = 4'd3,
        CLS_STUR    = 4'd4,
        CLS_CBZ     = 4'd5,
        CLS_CBNZ    = 4'd6,
        CLS_B       = 4'd7,
        CLS_SHIFT   = 4'd8
    } iclass_e;

    localparam logic [4:0] FS_AND = 5'b00000;
    localparam logic [4:0] FS_OR  = 5'b00100;
    localparam logic [4:0] FS_ADD = 5'b01000;
    localparam logic [4:0] FS_SUB = 5'b01010;
    localparam logic [4:0] FS_XOR = 5'b01100;
    localparam logic [4:0] FS_LSL = 5'b10000;
    localparam logic [4:0] FS_LSR = 5'b10100;

    // instr[31:21]
    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [10:0] OP_EOR  = 11'b11001010000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_LSL  = 11'b11010011011;
    localparam logic [10:0] OP_LSR  = 11'b11010011010;
    // instr[31:22]
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_EORI = 10'b1101001000;
    // instr[31:24]
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [7:0]  OP_CBNZ = 8'b10110101;
    // instr[31:26]
    localparam logic [5:0]  OP_B    = 6'b000101;

    localparam int CW_SA_LSB   = 20;
    localparam int CW_SB_LSB   = 15;
    localparam int CW_DA_LSB   = 10;
    localparam int CW_REGWRITE = 9;
    localparam int CW_MEMWRITE = 8;
    localparam int CW_FS_LSB   = 3;
    localparam int CW_BSEL     = 2;
    localparam int CW_EN_MEM   = 1;
    localparam int CW_EN_ALU   = 0;

    localparam logic [24:0] NOP_WORD = 25'b0;

    typedef struct packed {
        iclass_e     cls;
        logic [24:0] exec_cw;    // control word for the EXEC cycle
        logic [24:0] mem_cw;     // control word for the MEM cycle (LDUR only)
        logic [63:0] const_val;  // immediate driven while Bsel=1
        logic [63:0] br_off;     // sign-extended byte offset for branches
    } dec_t;

    function automatic logic [24:0] pack_cw(
        input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] da,
        input logic rw, input logic mw, input logic [4:0] fs,
        input logic bsel, input logic en_mem, input logic en_alu);
        logic [24:0] cw;
        cw = NOP_WORD;
        cw[CW_SA_LSB +: 5] = sa;
        cw[CW_SB_LSB +: 5] = sb;
        cw[CW_DA_LSB +: 5] = da;
        cw[CW_REGWRITE]    = rw;
        cw[CW_MEMWRITE]    = mw;
        cw[CW_FS_LSB +: 5] = fs;
        cw[CW_BSEL]        = bsel;
        cw[CW_EN_MEM]      = en_mem;
        cw[CW_EN_ALU]      = en_alu;
        return cw;
    endfunction

endpackage

// File: rtl/legv8_control_unit_if.sv
// legv8_control_unit_if: instruction handshake and control/branch bus.
//   master: fetch/datapath side (drives instruction, instr_valid, status)
//   slave : control unit (drives ready, ControlWord, constant, pulses)
interface legv8_control_unit_if;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  status;        // {V,C,N,Z}
    logic [24:0] ControlWord;
    logic [63:0] constant;
    logic        branch_taken;
    logic [63:0] branch_offset;
    logic        instr_done;
    logic        illegal_instr;

    modport master (
        output instruction, instr_valid, status,
        input  instr_ready, ControlWord, constant, branch_taken,
               branch_offset, instr_done, illegal_instr
    );

    modport slave (
        input  instruction, instr_valid, status,
        output instr_ready, ControlWord, constant, branch_taken,
               branch_offset, instr_done, illegal_instr
    );
endinterface

// File: rtl/legv8_decode.sv
// legv8_decode: combinational LEGv8 instruction decoder.
//   instr : 32-bit instruction word
//   dec   : instruction class, EXEC/MEM control words, immediate, branch offset
// LEGV8_SHIFT_EN defined: LSL/LSR decode as shift-immediate ops.
// LEGV8_SHIFT_EN undefined: LSL/LSR fall through to CLS_ILLEGAL.
module legv8_decode
    import legv8_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [10:0] op11;
    logic [9:0]  op10;
    logic [7:0]  op8;
    logic [5:0]  op6;
    logic [4:0]  rd, rn, rm;
    logic [63:0] imm12_z, imm9_s, off19, off26;
    logic [4:0]  fs;

    assign op11 = instr[31:21];
    assign op10 = instr[31:22];
    assign op8  = instr[31:24];
    assign op6  = instr[31:26];
    assign rd   = instr[4:0];    // Rd / Rt
    assign rn   = instr[9:5];
    assign rm   = instr[20:16];

    assign imm12_z = {52'b0, instr[21:10]};
    assign imm9_s  = {{55{instr[20]}}, instr[20:12]};
    assign off19   = {{43{instr[23]}}, instr[23:5], 2'b00};
    assign off26   = {{36{instr[25]}}, instr[25:0], 2'b00};

    always_comb begin
        dec = '0;
        dec.cls = CLS_ILLEGAL;
        fs = FS_AND;
        if (op11 inside {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR}) begin
            dec.cls = CLS_R;
            case (op11)
                OP_SUB:  fs = FS_SUB;
                OP_AND:  fs = FS_AND;
                OP_ORR:  fs = FS_OR;
                OP_EOR:  fs = FS_XOR;
                default: fs = FS_ADD;
            endcase
            dec.exec_cw = pack_cw(rn, rm, rd, 1'b1, 1'b0, fs, 1'b0, 1'b0, 1'b1);
        end else if (op11 == OP_LDUR) begin
            dec.cls       = CLS_LDUR;
            // EXEC only forms the address; the write-back happens in MEM
            dec.exec_cw   = pack_cw(rn, 5'd0, 5'd0, 1'b0, 1'b0, FS_ADD, 1'b1, 1'b0, 1'b0);
            dec.mem_cw    = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, FS_ADD, 1'b1, 1'b1, 1'b0);
            dec.const_val = imm9_s;
        end else if (op11 == OP_STUR) begin
            dec.cls       = CLS_STUR;
            dec.exec_cw   = pack_cw(rn, rd, 5'd0, 1'b0, 1'b1, FS_ADD, 1'b1, 1'b0, 1'b0);
            dec.const_val = imm9_s;
`ifdef LEGV8_SHIFT_EN
        end else if (op11 inside {OP_LSL, OP_LSR}) begin
            dec.cls       = CLS_SHIFT;
            fs            = (op11 == OP_LSL) ? FS_LSL : FS_LSR;
            dec.exec_cw   = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, fs, 1'b1, 1'b0, 1'b1);
            dec.const_val = {58'b0, instr[15:10]};
`endif
        end else if (op10 inside {OP_ADDI, OP_SUBI, OP_ANDI, OP_ORRI, OP_EORI}) begin
            dec.cls = CLS_I;
            case (op10)
                OP_SUBI: fs = FS_SUB;
                OP_ANDI: fs = FS_AND;
                OP_ORRI: fs = FS_OR;
                OP_EORI: fs = FS_XOR;
                default: fs = FS_ADD;
            endcase
            dec.exec_cw   = pack_cw(rn, 5'd0, rd, 1'b1, 1'b0, fs, 1'b1, 1'b0, 1'b1);
            dec.const_val = imm12_z;
        end else if (op8 inside {OP_CBZ, OP_CBNZ}) begin
            dec.cls     = (op8 == OP_CBZ) ? CLS_CBZ : CLS_CBNZ;
            // XZR | Rt drives the Z flag the BRANCH cycle tests
            dec.exec_cw = pack_cw(5'd31, rd, 5'd0, 1'b0, 1'b0, FS_OR, 1'b0, 1'b0, 1'b0);
            dec.br_off  = off19;
        end else if (op6 == OP_B) begin
            dec.cls    = CLS_B;
            dec.br_off = off26;
        end
    end

endmodule

// File: rtl/legv8_control_unit.sv
// legv8_control_unit: multi-cycle LEGv8 control FSM (IDLE/EXEC/MEM/BRANCH).
//   clock : rising-edge clock
//   reset : asynchronous active-low reset, aborts any in-flight instruction
//   bus   : slave side of legv8_control_unit_if (handshake, status flags,
//           ControlWord, constant, branch redirect, done/illegal pulses)
// All outputs except branch_taken in BRANCH come straight from flops; the
// conditional branch decision uses the live Z flag during BRANCH.
// Macro LEGV8_SHIFT_EN (see legv8_decode) enables LSL/LSR.
module legv8_control_unit
    import legv8_ctrl_pkg::*;
(
    input  logic clock,
    input  logic reset,
    legv8_control_unit_if.slave bus
);

    state_e      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic [24:0] cw_q, cw_d;
    logic [63:0] const_q, const_d;
    logic [63:0] off_q, off_d;
    logic        b_taken_q, b_taken_d;   // unconditional B pulse
    logic        cbnz_q, cbnz_d;         // inverts the Z test in BRANCH
    logic        done_q, done_d;
    logic        illegal_q, illegal_d;

    logic [31:0] dec_instr;
    dec_t        dec;
    logic [2:0]  unused_flags;

    // In IDLE decode the offered word so EXEC outputs are ready on entry;
    // afterwards the latched copy is the only source.
    assign dec_instr = (state_q == S_IDLE) ? bus.instruction : instr_q;

    legv8_decode u_decode (
        .instr (dec_instr),
        .dec   (dec)
    );

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        cw_d      = NOP_WORD;
        const_d   = 64'd0;
        off_d     = 64'd0;
        b_taken_d = 1'b0;
        cbnz_d    = 1'b0;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid) begin
                    instr_d   = bus.instruction;
                    state_d   = S_EXEC;
                    cw_d      = dec.exec_cw;
                    const_d   = dec.const_val;
                    b_taken_d = (dec.cls == CLS_B);
                    off_d     = (dec.cls == CLS_B) ? dec.br_off : 64'd0;
                    illegal_d = (dec.cls == CLS_ILLEGAL);
                    done_d    = !(dec.cls inside {CLS_LDUR, CLS_CBZ, CLS_CBNZ});
                end
            end
            S_EXEC: begin
                case (dec.cls)
                    CLS_LDUR: begin
                        state_d = S_MEM;
                        cw_d    = dec.mem_cw;
                        const_d = dec.const_val;
                        done_d  = 1'b1;
                    end
                    CLS_CBZ, CLS_CBNZ: begin
                        state_d = S_BRANCH;
                        off_d   = dec.br_off;
                        cbnz_d  = (dec.cls == CLS_CBNZ);
                        done_d  = 1'b1;
                    end
                    default: state_d = S_IDLE;
                endcase
            end
            default: state_d = S_IDLE;   // MEM, BRANCH
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            instr_q   <= 32'd0;
            cw_q      <= NOP_WORD;
            const_q   <= 64'd0;
            off_q     <= 64'd0;
            b_taken_q <= 1'b0;
            cbnz_q    <= 1'b0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            cw_q      <= cw_d;
            const_q   <= const_d;
            off_q     <= off_d;
            b_taken_q <= b_taken_d;
            cbnz_q    <= cbnz_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.instr_ready   = (state_q == S_IDLE);
    assign bus.ControlWord   = cw_q;
    assign bus.constant      = const_q;
    assign bus.branch_offset = off_q;
    assign bus.instr_done    = done_q;
    assign bus.illegal_instr = illegal_q;
    assign bus.branch_taken  = b_taken_q |
                               ((state_q == S_BRANCH) && (bus.status[0] ^ cbnz_q));

    assign unused_flags = bus.status[3:1];

endmodule

// File: tb/tb_legv8_control_unit.sv
module tb_legv8_control_unit;
    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    int   hs_cnt = 0;

    always #5 clock = ~clock;

    legv8_control_unit_if bus();

    legv8_control_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always @(posedge clock)
        if (reset && bus.instr_valid && bus.instr_ready) hs_cnt <= hs_cnt + 1;

    // Offer one instruction when ready; returns at the negedge of its EXEC cycle.
    task automatic issue(input logic [31:0] ins);
        int n;
        n = 0;
        @(negedge clock);
        while (!bus.instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (!bus.instr_ready) begin
            checks++; errors++;
            $display("FAIL ready_timeout got %b exp 1", bus.instr_ready);
        end
        bus.instruction = ins;
        bus.instr_valid = 1'b1;
        @(negedge clock);
        bus.instr_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instruction = 32'd0;
        bus.status = 4'd0;
        #12;
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %b exp 1", bus.instr_ready); end
        checks++; if (bus.ControlWord !== 25'd0) begin errors++; $display("FAIL rst_cw got %h exp 0", bus.ControlWord); end
        checks++; if (bus.constant !== 64'd0) begin errors++; $display("FAIL rst_const got %h exp 0", bus.constant); end
        checks++; if ({bus.branch_taken, bus.instr_done, bus.illegal_instr} !== 3'b000) begin
            errors++; $display("FAIL rst_pulses got %b exp 000", {bus.branch_taken, bus.instr_done, bus.illegal_instr}); end
        @(negedge clock);
        reset = 1'b1;
    endtask

    task automatic test_rtype();
        logic [31:0] ins [3] = '{32'h8B020023, 32'hCB0600A4, 32'hCA090107};
        logic [24:0] exp [3] = '{25'h110E41, 25'h531251, 25'h849E61};
        for (int k = 0; k < 3; k++) begin
            issue(ins[k]);
            checks++; if (bus.ControlWord !== exp[k]) begin errors++; $display("FAIL rtype_cw%0d got %h exp %h", k, bus.ControlWord, exp[k]); end
            checks++; if (bus.instr_done !== 1'b1 || bus.instr_ready !== 1'b0) begin
                errors++; $display("FAIL rtype_done%0d got %b%b exp 10", k, bus.instr_done, bus.instr_ready); end
            @(negedge clock);
            checks++; if (bus.instr_ready !== 1'b1 || bus.ControlWord !== 25'd0 || bus.instr_done !== 1'b0) begin
                errors++; $display("FAIL rtype_idle%0d got %b %h %b exp 1 0 0", k, bus.instr_ready, bus.ControlWord, bus.instr_done); end
        end
    endtask

    task automatic test_itype();
        issue(32'h910013E5);
        checks++; if (bus.ControlWord !== 25'b1111100000001011001000101) begin
            errors++; $display("FAIL addi_cw got %b exp 1111100000001011001000101", bus.ControlWord); end
        checks++; if (bus.constant !== 64'd4 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL addi_const got %h/%b exp 4/1", bus.constant, bus.instr_done); end
        issue(32'h923FFC62);
        checks++; if (bus.ControlWord !== 25'h300A05 || bus.constant !== 64'hFFF) begin
            errors++; $display("FAIL andi got %h/%h exp 300a05/fff", bus.ControlWord, bus.constant); end
    endtask

    task automatic test_ldur();
        issue(32'hF8408002);
        checks++; if (bus.ControlWord !== 25'h000044 || bus.constant !== 64'd8 || bus.instr_done !== 1'b0) begin
            errors++; $display("FAIL ldur_exec got %h/%h/%b exp 44/8/0", bus.ControlWord, bus.constant, bus.instr_done); end
        @(negedge clock);
        checks++; if (bus.ControlWord !== 25'h000A46 || bus.instr_done !== 1'b1 || bus.instr_ready !== 1'b0) begin
            errors++; $display("FAIL ldur_mem got %h/%b/%b exp a46/1/0", bus.ControlWord, bus.instr_done, bus.instr_ready); end
        @(negedge clock);
        checks++; if (bus.instr_ready !== 1'b1 || bus.ControlWord !== 25'd0) begin
            errors++; $display("FAIL ldur_idle got %b/%h exp 1/0", bus.instr_ready, bus.ControlWord); end
        issue(32'hF85F8002);
        checks++; if (bus.constant !== 64'hFFFF_FFFF_FFFF_FFF8) begin
            errors++; $display("FAIL ldur_neg got %h exp fffffffffffffff8", bus.constant); end
        @(negedge clock);
    endtask

    task automatic test_stur();
        issue(32'hF80083E1);
        checks++; if (bus.ControlWord !== 25'h1F08144 || bus.constant !== 64'd8 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL stur got %h/%h/%b exp 1f08144/8/1", bus.ControlWord, bus.constant, bus.instr_done); end
        @(negedge clock);
        checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL stur_ready got %b exp 1", bus.instr_ready); end
    endtask

    task automatic test_cbz();
        logic [31:0] ins [3] = '{32'hB4000083, 32'hB4000083, 32'hB5000083};
        logic [3:0]  st  [3] = '{4'b0001, 4'b0000, 4'b0000};
        logic        tk  [3] = '{1'b1, 1'b0, 1'b1};
        for (int k = 0; k < 3; k++) begin
            bus.status = st[k];
            issue(ins[k]);
            checks++; if (bus.ControlWord !== 25'h1F18020 || bus.branch_taken !== 1'b0 || bus.instr_done !== 1'b0) begin
                errors++; $display("FAIL cb_exec%0d got %h/%b/%b exp 1f18020/0/0", k, bus.ControlWord, bus.branch_taken, bus.instr_done); end
            @(negedge clock);
            checks++; if (bus.branch_taken !== tk[k] || bus.branch_offset !== 64'd16 || bus.instr_done !== 1'b1) begin
                errors++; $display("FAIL cb_branch%0d got %b/%h/%b exp %b/10/1", k, bus.branch_taken, bus.branch_offset, bus.instr_done, tk[k]); end
            @(negedge clock);
            checks++; if (bus.branch_taken !== 1'b0 || bus.instr_ready !== 1'b1) begin
                errors++; $display("FAIL cb_idle%0d got %b/%b exp 0/1", k, bus.branch_taken, bus.instr_ready); end
        end
        bus.status = 4'd0;
    endtask

    task automatic test_b();
        issue(32'h17FFFFFF);
        checks++; if (bus.branch_taken !== 1'b1 || bus.branch_offset !== 64'hFFFF_FFFF_FFFF_FFFC ||
                      bus.ControlWord !== 25'd0 || bus.instr_done !== 1'b1) begin
            errors++; $display("FAIL b_neg got %b/%h/%h/%b exp 1/fffffffffffffffc/0/1", bus.branch_taken, bus.branch_offset, bus.ControlWord, bus.instr_done); end
        @(negedge clock);
        checks++; if (bus.branch_taken !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL b_idle got %b/%b exp 0/1", bus.branch_taken, bus.instr_ready); end
        issue(32'h14000010);
        checks++; if (bus.branch_taken !== 1'b1 || bus.branch_offset !== 64'd64) begin
            errors++; $display("FAIL b_pos got %b/%h exp 1/40", bus.branch_taken, bus.branch_offset); end
    endtask

    task automatic test_illegal();
        issue(32'h00000000);
        checks++; if (bus.illegal_instr !== 1'b1 || bus.instr_done !== 1'b1 || bus.ControlWord !== 25'd0) begin
            errors++; $display("FAIL ill got %b/%b/%h exp 1/1/0", bus.illegal_instr, bus.instr_done, bus.ControlWord); end
        @(negedge clock);
        checks++; if (bus.illegal_instr !== 1'b0 || bus.instr_ready !== 1'b1) begin
            errors++; $display("FAIL ill_idle got %b/%b exp 0/1", bus.illegal_instr, bus.instr_ready); end
    endtask

    task automatic test_shift();
        issue(32'hD3600C41);
`ifdef LEGV8_SHIFT_EN
        checks++; if (bus.ControlWord !== 25'h200685 || bus.constant !== 64'd3 || bus.illegal_instr !== 1'b0) begin
            errors++; $display("FAIL lsl got %h/%h/%b exp 200685/3/0", bus.ControlWord, bus.constant, bus.illegal_instr); end
        issue(32'hD3400C41);
        checks++; if (bus.ControlWord !== 25'h2006A5) begin
            errors++; $display("FAIL lsr got %h exp 2006a5", bus.ControlWord); end
`else
        checks++; if (bus.illegal_instr !== 1'b1 || bus.ControlWord !== 25'd0) begin
            errors++; $display("FAIL lsl_ill got %b/%h exp 1/0", bus.illegal_instr, bus.ControlWord); end
`endif
    endtask

    task automatic test_reset_mid();
        issue(32'hF8408002);
        @(negedge clock);
        checks++; if (bus.ControlWord !== 25'h000A46) begin errors++; $display("FAIL rmid_mem got %h exp a46", bus.ControlWord); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.ControlWord !== 25'd0 || bus.instr_ready !== 1'b1 || bus.instr_done !== 1'b0 || bus.constant !== 64'd0) begin
            errors++; $display("FAIL rmid_abort got %h/%b/%b/%h exp 0/1/0/0", bus.ControlWord, bus.instr_ready, bus.instr_done, bus.constant); end
        @(negedge clock);
        reset = 1'b1;
        issue(32'h8B020023);
        checks++; if (bus.ControlWord !== 25'h110E41) begin errors++; $display("FAIL rmid_next got %h exp 110e41", bus.ControlWord); end
        @(negedge clock);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [3] = '{32'h8B020023, 32'hCB0600A4, 32'hCA090107};
        logic [24:0] exp [3] = '{25'h110E41, 25'h531251, 25'h849E61};
        int hs0;
        @(negedge clock);
        hs0 = hs_cnt;
        bus.instruction = ins[0];
        bus.instr_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++; if (bus.ControlWord !== exp[k]) begin errors++; $display("FAIL b2b_cw%0d got %h exp %h", k, bus.ControlWord, exp[k]); end
            // change the offered word while busy: must not disturb this EXEC
            if (k < 2) bus.instruction = ins[k+1];
            else bus.instr_valid = 1'b0;
            @(negedge clock);
            checks++; if (bus.instr_ready !== 1'b1 || bus.ControlWord !== 25'd0) begin
                errors++; $display("FAIL b2b_idle%0d got %b/%h exp 1/0", k, bus.instr_ready, bus.ControlWord); end
        end
        @(negedge clock);
        checks++; if (hs_cnt - hs0 !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", hs_cnt - hs0); end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_itype();
        test_ldur();
        test_stur();
        test_cbz();
        test_b();
        test_illegal();
        test_shift();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
